// File: rtl/buffer_lector.sv
// -----------------------------------------------------------------------------
// buffer_lector
//
// Pops pixels one at a time from a row buffer (FIFO with a fixed read
// latency) and presents them to a downstream filter stage through a
// valid/ready handshake. Only one read is ever outstanding. A read is
// started only when the buffer is not empty and reading is enabled.
//
// Optional feature: define BUFFER_LECTOR_EOL_EN to add a column counter
// (col_cnt) and an end-of-line flag (eol). The default build leaves this
// feature out completely.
//
// Parameters
//   DATA_W   pixel width in bits
//   READ_LAT cycles from read_req high to valid fifo_data (1..4)
//   LINE_LEN pixels per image row (only used with BUFFER_LECTOR_EOL_EN)
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low reset
//   enable     in   level, allows new reads from the row buffer
//   fifo_empty in   row buffer empty flag
//   fifo_data  in   row buffer read data
//   read_req   out  one-cycle pop pulse to the row buffer
//   read_en    out  read enable level (follows enable out of reset)
//   pix_data   out  pixel to the downstream stage
//   pix_valid  out  pix_data valid
//   pix_ready  in   downstream accepts (transfer = pix_valid & pix_ready)
//   busy       out  1 whenever the reader is not idle
//   eol        out  (optional) last pixel of a row is being presented
//   col_cnt    out  (optional) column index of the presented pixel
// -----------------------------------------------------------------------------
module buffer_lector #(
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1,
  parameter int LINE_LEN = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        fifo_empty,
  input  logic [DATA_W-1:0]           fifo_data,
  output logic                        read_req,
  output logic                        read_en,
  output logic [DATA_W-1:0]           pix_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        busy
`ifdef BUFFER_LECTOR_EOL_EN
  ,
  output logic                        eol,
  output logic [$clog2(LINE_LEN)-1:0] col_cnt
`endif
);

  // Last value of the latency counter; the counter runs 0..READ_LAT-1
  // while waiting for the row buffer data.
  localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic                armed_q, armed_d;
  logic [DATA_W-1:0]   pix_data_q, pix_data_d;
  logic                read_req_q, read_req_d;
  logic                pix_valid_q, pix_valid_d;
  logic                busy_q, busy_d;

  logic                can_read_s;
  logic                xfer_s;

  // A new read is allowed only one full cycle after reset release (armed),
  // while enabled and while the buffer holds data.
  assign can_read_s = armed_q & enable & ~fifo_empty;
  assign xfer_s     = pix_valid_q & pix_ready;

  // Next-state, latency counter and pixel capture.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pix_data_d = pix_data_q;
    armed_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (can_read_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        state_d    = WAIT;
        wait_cnt_d = 3'd0;
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          // Data is valid in the last count cycle; latch it on this edge.
          pix_data_d = fifo_data;
          wait_cnt_d = 3'd0;
          state_d    = VALID;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
          state_d    = WAIT;
        end
      end
      VALID: begin
        if (xfer_s) begin
          // Back-to-back reads skip IDLE when more data is available.
          if (can_read_s) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = VALID;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 3'd0;
      end
    endcase
  end

  // Output flags are decoded from the next state so they come out of flops
  // and line up exactly with the state they describe.
  always_comb begin
    read_req_d  = 1'b0;
    pix_valid_d = 1'b0;
    busy_d      = 1'b0;
    if (state_d == REQ) begin
      read_req_d = 1'b1;
    end else begin
      read_req_d = 1'b0;
    end
    if (state_d == VALID) begin
      pix_valid_d = 1'b1;
    end else begin
      pix_valid_d = 1'b0;
    end
    if (state_d != IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State, counter, captured pixel and registered output flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 3'd0;
      armed_q     <= 1'b0;
      pix_data_q  <= {DATA_W{1'b0}};
      read_req_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      armed_q     <= armed_d;
      pix_data_q  <= pix_data_d;
      read_req_q  <= read_req_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign read_req  = read_req_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign busy      = busy_q;
  // The enable level is passed through, forced low while in reset.
  assign read_en   = enable & reset;

`ifdef BUFFER_LECTOR_EOL_EN
  localparam int                COL_W    = $clog2(LINE_LEN);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_LEN - 1);

  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic             eol_q, eol_d;

  // Column index advances on every accepted pixel and wraps at row end.
  always_comb begin
    col_cnt_d = col_cnt_q;
    if (xfer_s) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = {COL_W{1'b0}};
      end else begin
        col_cnt_d = col_cnt_q + COL_W'(1);
      end
    end else begin
      col_cnt_d = col_cnt_q;
    end
    if ((state_d == VALID) && (col_cnt_d == COL_LAST)) begin
      eol_d = 1'b1;
    end else begin
      eol_d = 1'b0;
    end
  end

  // Column counter and end-of-line flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt_q <= {COL_W{1'b0}};
      eol_q     <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      eol_q     <= eol_d;
    end
  end

  assign col_cnt = col_cnt_q;
  assign eol     = eol_q;
`else
  // LINE_LEN only matters for the column counter.
  logic unused_line_len_s;
  assign unused_line_len_s = (LINE_LEN > 0);
`endif

endmodule
